// File: rtl/fp_to_int.sv
// Three-stage FP32 -> signed INT32 converter (vfcvt.x.f) with RNE/RTZ rounding,
// saturation and invalid/inexact flags; the whole pipeline freezes on output backpressure.
module fp_to_int #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_nv,
    output logic             out_nx,
    output logic [TAG_W-1:0] out_tag
);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: unpack / classify ----------------
    logic [7:0]        in_exp;
    logic [22:0]       in_frac;
    assign in_exp  = in_data[30:23];
    assign in_frac = in_data[22:0];

    logic              s1_valid;
    logic              s1_sign;
    logic              s1_zero;
    logic              s1_special;
    logic              s1_frac_nz;
    logic [23:0]       s1_mant;
    logic signed [9:0] s1_e;
    logic              s1_rm;
    logic [TAG_W-1:0]  s1_tag;

    // ---------------- S2: align ----------------
    logic [2:0]  sh_l;
    logic [4:0]  sh_r;
    logic [55:0] wide;
    logic [31:0] a_mag;
    logic        a_g;
    logic        a_s;
    logic        a_ovf;

    assign sh_l = s1_e[2:0] + 3'd1;   // (e - 23) mod 8
    assign sh_r = 5'd23 - s1_e[4:0];
    assign wide = {8'b0, s1_mant, 24'b0} >> sh_r;

    always_comb begin
        a_mag = '0;
        a_g   = 1'b0;
        a_s   = 1'b0;
        a_ovf = 1'b0;
        if (s1_e >= 10'sd31) begin
            // -2^31 exactly is the one representable value with e == 31
            if (s1_e == 10'sd31 && s1_sign && !s1_frac_nz)
                a_mag = 32'h8000_0000;
            else
                a_ovf = 1'b1;
        end else if (s1_e >= 10'sd23) begin
            a_mag = {8'b0, s1_mant} << sh_l;
        end else if (s1_e >= 10'sd0) begin
            a_mag = wide[55:24];
            a_g   = wide[23];
            a_s   = |wide[22:0];
        end else if (s1_e == -10'sd1) begin
            a_g = 1'b1;
            a_s = s1_frac_nz;
        end else begin
            a_s = 1'b1;
        end
    end

    logic              s2_valid;
    logic              s2_sign;
    logic              s2_zero;
    logic              s2_special;
    logic              s2_frac_nz;
    logic [31:0]       s2_mag;
    logic              s2_g;
    logic              s2_s;
    logic              s2_ovf;
    logic              s2_rm;
    logic [TAG_W-1:0]  s2_tag;

    // ---------------- S3: round / negate / saturate ----------------
    logic        inc;
    logic [32:0] rounded;
    logic        too_big;
    logic [31:0] sat_val;
    logic [31:0] r_data;
    logic        r_nv;
    logic        r_nx;

    assign inc     = ~s2_rm & s2_g & (s2_s | s2_mag[0]);
    assign rounded = {1'b0, s2_mag} + {32'b0, inc};
    assign too_big = s2_ovf | (s2_sign ? (rounded > 33'h0_8000_0000)
                                       : (rounded >= 33'h0_8000_0000));
    assign sat_val = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

    always_comb begin
        r_data = s2_sign ? (~rounded[31:0] + 32'd1) : rounded[31:0];
        r_nv   = 1'b0;
        r_nx   = s2_g | s2_s;
        if (s2_special) begin
            r_data = s2_frac_nz ? 32'h7FFF_FFFF : sat_val;
            r_nv   = 1'b1;
            r_nx   = 1'b0;
        end else if (s2_zero) begin
            r_data = '0;
            r_nx   = s2_frac_nz;
        end else if (too_big) begin
            r_data = sat_val;
            r_nv   = 1'b1;
            r_nx   = 1'b0;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_zero    <= 1'b0;
            s1_special <= 1'b0;
            s1_frac_nz <= 1'b0;
            s1_mant    <= '0;
            s1_e       <= '0;
            s1_rm      <= 1'b0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_zero    <= 1'b0;
            s2_special <= 1'b0;
            s2_frac_nz <= 1'b0;
            s2_mag     <= '0;
            s2_g       <= 1'b0;
            s2_s       <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_rm      <= 1'b0;
            s2_tag     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nv     <= 1'b0;
            out_nx     <= 1'b0;
            out_tag    <= '0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_data[31];
            s1_zero    <= (in_exp == 8'h00);
            s1_special <= (in_exp == 8'hFF);
            s1_frac_nz <= |in_frac;
            s1_mant    <= {1'b1, in_frac};
            s1_e       <= $signed({2'b00, in_exp}) - 10'sd127;
            s1_rm      <= in_rm;
            s1_tag     <= in_tag;

            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_zero    <= s1_zero;
            s2_special <= s1_special;
            s2_frac_nz <= s1_frac_nz;
            s2_mag     <= a_mag;
            s2_g       <= a_g;
            s2_s       <= a_s;
            s2_ovf     <= a_ovf;
            s2_rm      <= s1_rm;
            s2_tag     <= s1_tag;

            out_valid  <= s2_valid;
            out_data   <= r_data;
            out_nv     <= r_nv;
            out_nx     <= r_nx;
            out_tag    <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed rounding/boundary vectors, latency,
// backpressure, reset mid-stream and a randomized stream against an arithmetic model.
module tb_fp_to_int;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_nv;
    logic             out_nx;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    fp_to_int #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rm     (in_rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nv    (out_nv),
        .out_nx    (out_nx),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [31:0]      data;
        logic             nv;
        logic             nx;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    exp_t             in_exp;
    int               n_cmp = 0;
    int               n_err = 0;
    int               n_out = 0;
    bit               accepted;
    bit               prev_stall = 1'b0;
    logic [31:0]      prev_data;
    logic             prev_nv, prev_nx;
    logic [TAG_W-1:0] prev_tag;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Reference: exact value mant * 2^(e-23), rounded as a fraction q + rr/2^d.
    function automatic exp_t model(input logic [31:0] x, input logic rm, input logic [TAG_W-1:0] tag);
        exp_t   m;
        longint mant, q, rr, half, v;
        int     e, d;
        m.tag  = tag;
        m.nv   = 1'b0;
        m.nx   = 1'b0;
        m.data = '0;
        e    = int'(x[30:23]) - 127;
        mant = longint'({1'b1, x[22:0]});
        if (x[30:23] == 8'hFF) begin
            m.nv   = 1'b1;
            m.data = (x[22:0] != 0 || !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (x[30:23] == 8'h00) begin
            m.nx = (x[22:0] != 0);
        end else begin
            rr = 0;
            if (e > 40) begin
                q = 64'h1_0000_0000;
            end else if (e >= 23) begin
                q = mant << (e - 23);
            end else begin
                d = 23 - e;
                if (d >= 26) begin
                    q  = 0;
                    rr = 1;
                end else begin
                    q    = mant >> d;
                    rr   = mant - (q << d);
                    half = longint'(1) << (d - 1);
                    if (!rm && (rr > half || (rr == half && q[0]))) q = q + 1;
                end
            end
            v = x[31] ? -q : q;
            if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
                m.nv   = 1'b1;
                m.data = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                m.data = v[31:0];
                m.nx   = (rr != 0);
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        int unsigned sel;
        x   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0)      x[30:23] = 8'h00;
        else if (sel == 1) x[30:23] = 8'hFF;
        else if (sel < 13) x[30:23] = 8'($urandom_range(118, 160));
        return x;
    endfunction

    task automatic drive(input logic [31:0] d, input logic rm, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_data  = d;
        in_rm    = rm;
        in_tag   = tag;
        in_exp   = model(d, rm, tag);
    endtask

    // One clock: checks at the falling edge, returns 1ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (!reset) begin
            chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_flags", {30'b0, out_nv, out_nx}, {30'b0, prev_nv, prev_nx});
                chk("stall_tag", 32'(out_tag), 32'(prev_tag));
            end
            if (out_valid && out_ready) begin
                chk("unexpected_out", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_out++;
                    chk("data", out_data, e.data);
                    chk("nv", 32'(out_nv), 32'(e.nv));
                    chk("nx", 32'(out_nx), 32'(e.nx));
                    chk("tag", 32'(out_tag), 32'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_exp);
                accepted = 1'b1;
            end
        end
        prev_stall = !reset && out_valid && !out_ready;
        prev_data  = out_data;
        prev_nv    = out_nv;
        prev_nx    = out_nx;
        prev_tag   = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic latency_test(input logic [31:0] d, input logic [TAG_W-1:0] tag, input logic [31:0] expd,
                                input logic enx);
        out_ready = 1'b1;
        drive(d, 1'b0, tag);
        in_exp.data = expd;
        in_exp.nv   = 1'b0;
        in_exp.nx   = enx;
        tick();
        chk("lat_accept", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_cycle2", 32'(out_valid), 32'd0);
        tick();
        chk("lat_cycle3_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle3_data", out_data, expd);
        chk("lat_cycle3_tag", 32'(out_tag), 32'(tag));
        tick();
    endtask

    logic [31:0] vin [18] = '{32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'hC0200000,
                              32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'hC0200000,
                              32'h3F000000, 32'h3F400000, 32'h3F400000, 32'h00000000,
                              32'h00000001, 32'hCF000000, 32'h4F000000, 32'h4EFFFFFF,
                              32'h7FC00000, 32'hFF800000};
    logic        vrm [18] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] vout[18] = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFE, 32'd3, 32'd1, 32'd2, 32'hFFFFFFFE,
                              32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'h7FFFFFFF,
                              32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000};
    logic        vnv [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
    logic        vnx [18] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        logic [31:0] bp_data [8];
        int          sent;
        int          c;
        int          out_base;
        bit          holding;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rm     = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        in_exp    = model(32'h0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", {30'b0, out_nv, out_nx}, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // Directed vectors at full rate
        for (int i = 0; i < 18; i++) begin
            drive(vin[i], vrm[i], TAG_W'(i));
            in_exp.data = vout[i];
            in_exp.nv   = vnv[i];
            in_exp.nx   = vnx[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("directed_drained", 32'(sb.size()), 32'd0);
        chk("directed_count", 32'(n_out), 32'd18);

        latency_test(32'h42280000, TAG_W'(9), 32'd42, 1'b0);

        // Backpressure: out_ready low for relative cycles 4..9
        for (int i = 0; i < 8; i++) bp_data[i] = rand_fp();
        out_base = n_out;
        sent = 0;
        c = 0;
        while ((sent < 8 || sb.size() > 0) && c < 60) begin
            if (sent < 8) drive(bp_data[sent], 1'($urandom_range(0, 1)), TAG_W'(16 + sent));
            else in_valid = 1'b0;
            out_ready = !(c >= 4 && c <= 9);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'(!(c >= 4 && c <= 9)));
            tick();
            if (accepted) sent++;
            c++;
        end
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_results", 32'(n_out - out_base), 32'd8);
        chk("bp_drained", 32'(sb.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Randomized stream with random bubbles and backpressure
        holding = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!holding) begin
                if ($urandom_range(0, 9) < 8) drive(rand_fp(), 1'($urandom_range(0, 1)), TAG_W'($urandom));
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            holding = in_valid && !accepted;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("rand_drained", 32'(sb.size()), 32'd0);

        // Reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            drive(rand_fp(), 1'b0, TAG_W'(i + 1));
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        prev_stall = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        latency_test(32'hC0F00000, TAG_W'(7), 32'hFFFFFFF8, 1'b1);
        repeat (3) tick();
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
